multi_channel_blinker: RTL and testbench
========================================

# multi_channel_blinker

Parametrised, multi-channel successor to the single-channel selective blink counter. A shared prescaler generates a base tick. Each of NUM_CH channels drives one LED output in one of four modes: off, on, blink, or burst. Each channel has its own enable and a per-channel power-of-two rate select. The block sits between board-level control logic (switches, UART command decoder) and the LED pins.

## Interface
- NUM_CH, 4, number of independent output channels
- TICK_COUNT, 250000, clocks per base tick (10 ms at 25 MHz); must be ≥ 2
- RATE_BITS, 2, width of each channel's rate field; half-period = 2^rate ticks
- BURST_LEN, 3, pulses per burst in BURST mode; must be ≥ 1

- i_Clk  input  1  system clock; all logic on rising edge
- i_Rst  input  1  reset, synchronous, active-high
- i_Enable  input  NUM_CH  per-channel enable; bit c controls channel c
- i_Mode  input  2*NUM_CH  channel c mode in [2c+1:2c]: 0 OFF, 1 ON, 2 BLINK, 3 BURST
- i_Rate  input  RATE_BITS*NUM_CH  channel c rate in [RATE_BITS*c +: RATE_BITS]
- o_Toggle  output  NUM_CH  registered LED drive per channel
- o_Tick  output  1  base-tick strobe, high for one clock per TICK_COUNT clocks

## Operation
- Prescaler counts 0..TICK_COUNT-1 and wraps. Width is $clog2(TICK_COUNT). o_Tick is high in the cycle the prescaler holds TICK_COUNT-1.
- Per channel: the half-period counter has width 2^RATE_BITS bits and advances only on o_Tick. A half-period completes on a tick when counter == 2^rate − 1; the counter then clears.
- OFF: o_Toggle 0; counters held at 0.
- ON: o_Toggle 1.
- BLINK: starts with o_Toggle 0; inverts at every half-period completion.
- BURST FSM states:
  - B_LOW (out 0): half-period complete → B_HIGH.
  - B_HIGH (out 1): half-period complete → increment pulse count; go to B_PAUSE if count == BURST_LEN, else B_LOW.
  - B_PAUSE (out 0): lasts 2*BURST_LEN half-periods, then → B_LOW with pulse count 0. Entry state is B_LOW.
  - Pulse/pause counter width is $clog2(2*BURST_LEN+1).
- Restart: any change in a channel's mode or rate field versus its registered copy restarts that channel. Counters clear, FSM goes to B_LOW, o_Toggle goes to 0, and then the new mode is applied. ON takes effect the cycle after the change.
- Enable low: o_Toggle 0; counters and FSM held at entry state. The prescaler keeps running.
- Precedence per channel, highest first: i_Rst > !i_Enable > mode/rate change > tick event.

## Timing
- Reset values: o_Toggle all 0, o_Tick 0, prescaler 0, all FSMs at B_LOW, all counters 0, stored mode/rate copies 0.
- After i_Rst deasserts, the first o_Tick is in the TICK_COUNT-th cycle. o_Tick period is exactly TICK_COUNT clocks.
- Channel outputs change in the cycle after the o_Tick cycle that completes a half-period. There is one register of latency.
- When a channel enters BLINK/BURST, the first rise comes between (2^rate−1)*TICK_COUNT+1 and 2^rate*TICK_COUNT clocks later, because tick phase is free-running.
- Max rate: 2^(2^RATE_BITS−1) ticks per half-period. The counter never overflows.
- Reset mid-burst: all state returns to reset values on the next edge, regardless of other inputs.

## Structure
- Package blink_pkg: mode encodings (MODE_OFF/ON/BLINK/BURST), BURST FSM state encoding, 2-bit mode typedef.
- Sub-module blink_channel: one per channel via generate loop. Contains the half-period counter, mode/rate registers, BURST FSM, and output register. Takes the tick as an input.
- Top holds the prescaler and o_Tick decode only.

## Test plan
Parameters: TICK_COUNT=4, RATE_BITS=2, BURST_LEN=3, NUM_CH=4.
- Reset for 2 cycles, then release: all outputs 0. o_Tick first high in the 4th cycle after release, then every 4 clocks.
- ch0 ON, ch1 OFF, ch2 ON with i_Enable[2]=0: o_Toggle = 4'b0001 one cycle after mode applied. Raising i_Enable[2] gives 4'b0101 next cycle.
- ch0 BLINK rate 0, ch1 BLINK rate 2: ch0 toggles every 4 clocks; ch1 toggles every 16 clocks, starting from 0.
- ch3 BURST rate 0: out pattern per tick is 0,1,0,1,0,1 then 0 for 6 ticks, repeating every 12 ticks (48 clocks).
- ch0 BLINK while high, switch rate 0→1: o_Toggle[0] drops to 0 next cycle. It then toggles every 8 clocks.
- Assert i_Rst during B_HIGH of ch3 coinciding with o_Tick and a mode change: all outputs 0 next cycle, prescaler 0.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared encodings for the multi-channel LED blinker.
package blink_pkg;

    // Per-channel drive mode, two bits per channel on the i_Mode bus.
    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_t;

    // BURST pattern states; B_LOW is also the entry/restart state.
    typedef enum logic [1:0] {
        B_LOW   = 2'd0,
        B_HIGH  = 2'd1,
        B_PAUSE = 2'd2
    } burst_state_t;

endpackage

// File: rtl/blink_channel.sv
// One LED channel: half-period timer, mode/rate copies, BURST FSM and output register.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   B_LOW   | output low, waiting for the half-period that starts a pulse
//   B_HIGH  | output high; the pulse count advances when this half-period ends
//   B_PAUSE | output low for 2*BURST_LEN half-periods, then back to B_LOW
module blink_channel
    import blink_pkg::*;
#(
    parameter int RATE_BITS = 2,
    parameter int BURST_LEN = 3
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Enable,
    input  mode_t                i_Mode,
    input  logic [RATE_BITS-1:0] i_Rate,
    input  logic                 i_Tick,
    output logic                 o_Toggle
);

    // The counter is wide enough to hold 2^rate - 1 for the largest rate.
    localparam int CW = 2 ** RATE_BITS;
    localparam int PW = $clog2(2 * BURST_LEN + 1);

    mode_t                r_mode;
    logic [RATE_BITS-1:0] r_rate;
    logic [CW-1:0]        r_cnt;
    logic [PW-1:0]        r_pcnt;
    burst_state_t         r_state;
    logic                 r_toggle;

    mode_t                w_mode_nx;
    logic [RATE_BITS-1:0] w_rate_nx;
    logic [CW-1:0]        w_cnt_nx;
    logic [PW-1:0]        w_pcnt_nx;
    burst_state_t         w_state_nx;
    logic                 w_toggle_nx;
    logic                 w_change;
    logic                 w_done;
    logic [CW-1:0]        w_term;
    logic [PW-1:0]        w_pcnt_inc;

    assign w_change   = (i_Mode != r_mode) || (i_Rate != r_rate);
    assign w_term     = (CW'(1) << r_rate) - CW'(1);
    assign w_done     = i_Tick && (r_cnt == w_term);
    assign w_pcnt_inc = r_pcnt + PW'(1);

    // State register: reset clears everything regardless of other inputs.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_mode   <= MODE_OFF;
            r_rate   <= '0;
            r_cnt    <= '0;
            r_pcnt   <= '0;
            r_state  <= B_LOW;
            r_toggle <= 1'b0;
        end else begin
            r_mode   <= w_mode_nx;
            r_rate   <= w_rate_nx;
            r_cnt    <= w_cnt_nx;
            r_pcnt   <= w_pcnt_nx;
            r_state  <= w_state_nx;
            r_toggle <= w_toggle_nx;
        end
    end

    // Next-state logic: disable beats restart-on-change, which beats tick events.
    always_comb begin
        // The copies track the inputs even while disabled, so re-enabling
        // does not trigger a spurious restart.
        w_mode_nx   = i_Mode;
        w_rate_nx   = i_Rate;
        w_cnt_nx    = '0;
        w_pcnt_nx   = '0;
        w_state_nx  = B_LOW;
        w_toggle_nx = 1'b0;

        if (i_Enable && !w_change) begin
            case (r_mode)
                MODE_OFF: begin
                    w_toggle_nx = 1'b0;
                end
                MODE_ON: begin
                    w_toggle_nx = 1'b1;
                end
                MODE_BLINK: begin
                    w_toggle_nx = r_toggle;
                    if (w_done) begin
                        w_toggle_nx = !r_toggle;
                    end else if (i_Tick) begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end else begin
                        w_cnt_nx = r_cnt;
                    end
                end
                MODE_BURST: begin
                    w_pcnt_nx  = r_pcnt;
                    w_state_nx = r_state;
                    if (w_done) begin
                        case (r_state)
                            B_LOW: begin
                                w_state_nx = B_HIGH;
                            end
                            B_HIGH: begin
                                if (w_pcnt_inc == PW'(BURST_LEN)) begin
                                    w_state_nx = B_PAUSE;
                                    w_pcnt_nx  = '0;
                                end else begin
                                    w_state_nx = B_LOW;
                                    w_pcnt_nx  = w_pcnt_inc;
                                end
                            end
                            B_PAUSE: begin
                                if (w_pcnt_inc == PW'(2 * BURST_LEN)) begin
                                    w_state_nx = B_LOW;
                                    w_pcnt_nx  = '0;
                                end else begin
                                    w_pcnt_nx = w_pcnt_inc;
                                end
                            end
                            default: begin
                                w_state_nx = B_LOW;
                                w_pcnt_nx  = '0;
                            end
                        endcase
                    end else if (i_Tick) begin
                        w_cnt_nx = r_cnt + CW'(1);
                    end else begin
                        w_cnt_nx = r_cnt;
                    end
                    w_toggle_nx = (w_state_nx == B_HIGH);
                end
                default: begin
                    w_toggle_nx = 1'b0;
                end
            endcase
        end
    end

    assign o_Toggle = r_toggle;

endmodule

// File: rtl/multi_channel_blinker.sv
// Multi-channel LED blinker: shared base-tick prescaler feeding NUM_CH channels.
module multi_channel_blinker
    import blink_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int TICK_COUNT = 250000,
    parameter int RATE_BITS  = 2,
    parameter int BURST_LEN  = 3
) (
    input  logic                          i_Clk,
    input  logic                          i_Rst,
    input  logic [NUM_CH-1:0]             i_Enable,
    input  logic [2*NUM_CH-1:0]           i_Mode,
    input  logic [RATE_BITS*NUM_CH-1:0]   i_Rate,
    output logic [NUM_CH-1:0]             o_Toggle,
    output logic                          o_Tick
);

    localparam int PW = $clog2(TICK_COUNT);

    logic [PW-1:0] r_presc;
    logic          w_tick;

    assign w_tick = (r_presc == PW'(TICK_COUNT - 1));
    assign o_Tick = w_tick;

    // Free-running prescaler; only reset stops it, channel enables do not.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        blink_channel #(
            .RATE_BITS (RATE_BITS),
            .BURST_LEN (BURST_LEN)
        ) u_ch (
            .i_Clk    (i_Clk),
            .i_Rst    (i_Rst),
            .i_Enable (i_Enable[c]),
            .i_Mode   (mode_t'(i_Mode[2*c +: 2])),
            .i_Rate   (i_Rate[RATE_BITS*c +: RATE_BITS]),
            .i_Tick   (w_tick),
            .o_Toggle (o_Toggle[c])
        );
    end

endmodule

// File: tb/tb_multi_channel_blinker.sv
// Scoreboard bench: a tick-count reference model predicts outputs per edge,
// a monitor pops and compares one cycle of DUT outputs per edge.
module tb_multi_channel_blinker;

    localparam int NUM_CH     = 4;
    localparam int TICK_COUNT = 4;
    localparam int RATE_BITS  = 2;
    localparam int BURST_LEN  = 3;

    logic                        clk;
    logic                        rst;
    logic [NUM_CH-1:0]           en;
    logic [2*NUM_CH-1:0]         mode;
    logic [RATE_BITS*NUM_CH-1:0] rate;
    logic [NUM_CH-1:0]           tog;
    logic                        tick;

    typedef struct packed {
        logic [NUM_CH-1:0] tog;
        logic              tick;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_cyc = 0;

    int                m_presc = 0;
    int                m_ticks[NUM_CH];
    int                m_mode[NUM_CH];
    int                m_rate[NUM_CH];
    logic [NUM_CH-1:0] m_out = '0;

    multi_channel_blinker #(
        .NUM_CH     (NUM_CH),
        .TICK_COUNT (TICK_COUNT),
        .RATE_BITS  (RATE_BITS),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .i_Clk    (clk),
        .i_Rst    (rst),
        .i_Enable (en),
        .i_Mode   (mode),
        .i_Rate   (rate),
        .o_Toggle (tog),
        .o_Tick   (tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Output level from the number of ticks seen since the channel (re)started.
    function automatic logic level(int md, int rt, int t);
        int h;
        int p;
        h = t >> rt;
        p = h % (4 * BURST_LEN);
        case (md)
            1:       return 1'b1;
            2:       return (h % 2) == 1;
            3:       return (p < 2 * BURST_LEN) && ((p % 2) == 1);
            default: return 1'b0;
        endcase
    endfunction

    // Reference model: advance on each edge and push the expected post-edge outputs.
    always @(posedge clk) begin
        exp_t e;
        bit   m_tick;
        int   md;
        int   rt;
        m_tick = (m_presc == TICK_COUNT - 1);
        if (rst) begin
            m_presc = 0;
            m_out   = '0;
            for (int c = 0; c < NUM_CH; c++) begin
                m_ticks[c] = 0;
                m_mode[c]  = 0;
                m_rate[c]  = 0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                md = int'(mode[2*c +: 2]);
                rt = int'(rate[RATE_BITS*c +: RATE_BITS]);
                if (!en[c] || md != m_mode[c] || rt != m_rate[c]) begin
                    m_mode[c]  = md;
                    m_rate[c]  = rt;
                    m_ticks[c] = 0;
                    m_out[c]   = 1'b0;
                end else begin
                    if (m_tick && md >= 2) m_ticks[c] = m_ticks[c] + 1;
                    m_out[c] = level(md, rt, m_ticks[c]);
                end
            end
            m_presc = (m_presc == TICK_COUNT - 1) ? 0 : m_presc + 1;
        end
        e.tog  = m_out;
        e.tick = (m_presc == TICK_COUNT - 1);
        q.push_back(e);
    end

    // Monitor: compare the DUT against the oldest expectation just after each edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        n_cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_vec++;
            if (tog !== e.tog || tick !== e.tick) begin
                n_err++;
                $display("FAIL outputs cycle %0d: o_Toggle=%b o_Tick=%b, expected o_Toggle=%b o_Tick=%b",
                         n_cyc, tog, tick, e.tog, e.tick);
            end
        end
    end

    task automatic check(string what, logic [7:0] got, logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", what, got, exp);
        end
    endtask

    task automatic cycles(int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst  = 1'b1;
        en   = '0;
        mode = '0;
        rate = '0;
        cycles(2);
        check("reset o_Toggle", 8'(tog), 8'h00);
        check("reset o_Tick", 8'(tick), 8'h00);
        rst = 1'b0;
        cycles(8);

        // ch0 ON, ch1 OFF, ch2 ON but disabled, then enable ch2.
        en        = 4'b1011;
        mode[1:0] = 2'd1;
        mode[3:2] = 2'd0;
        mode[5:4] = 2'd1;
        cycles(3);
        en[2] = 1'b1;
        cycles(3);

        // ch0 BLINK r0, ch1 BLINK r2, ch2 OFF, ch3 BURST r0.
        en        = '1;
        mode[1:0] = 2'd2;
        rate[1:0] = 2'd0;
        mode[3:2] = 2'd2;
        rate[3:2] = 2'd2;
        mode[5:4] = 2'd0;
        mode[7:6] = 2'd3;
        rate[7:6] = 2'd0;
        cycles(120);

        // Change ch0 rate while its output is high.
        for (int i = 0; i < 20 && !tog[0]; i++) @(negedge clk);
        check("wait for ch0 high", 8'(tog[0]), 8'h01);
        rate[1:0] = 2'd1;
        cycles(40);

        // Reset during a ch3 pulse, on a tick cycle, together with a mode change.
        for (int i = 0; i < 100 && !(tog[3] && tick); i++) @(negedge clk);
        check("wait for ch3 high on tick", 8'(tog[3] && tick), 8'h01);
        rst       = 1'b1;
        mode[1:0] = 2'd3;
        @(negedge clk);
        rst = 1'b0;
        cycles(30);

        // Randomized segments.
        for (int s = 0; s < 150; s++) begin
            en = ($urandom_range(0, 3) == 0) ? NUM_CH'($urandom) : '1;
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 2) == 0) begin
                    mode[2*c +: 2]                 = 2'($urandom_range(0, 3));
                    rate[RATE_BITS*c +: RATE_BITS] = RATE_BITS'($urandom);
                end
            end
            rst = ($urandom_range(0, 15) == 0);
            @(negedge clk);
            rst = 1'b0;
            cycles($urandom_range(1, 80));
        end

        cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        if (n_err == 0 && n_vec > 0) $display("PASS");
        else $display("FAIL");
        $finish;
    end

endmodule
